// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control FSM: sequences FETCH/DECODE/EXEC/MEM/WB per
// instruction class and drives datapath enables plus ALU operation select.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        zero,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_write,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic        mem_to_reg,
  output logic        pc_src,
  output logic [3:0]  alu_op,
  output logic        illegal,
  output logic [2:0]  watch_state,
  output logic [31:0] inst_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_R   = 3'd0,
    C_I   = 3'd1,
    C_LW  = 3'd2,
    C_SW  = 3'd3,
    C_BEQ = 3'd4,
    C_JAL = 3'd5,
    C_LUI = 3'd6,
    C_BAD = 3'd7
  } cls_t;

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d, dec_cls;
  logic        illegal_q, illegal_d;
  logic [31:0] inst_count_q, inst_count_d;
  logic        done;

  // Only funct7[5] matters for the supported ALU operations.
  logic unused_funct7;
  assign unused_funct7 = &{1'b0, funct7[6], funct7[4:0]};

  // alt selects SUB/SRA; SUB is only reachable when allow_sub is set (R-type).
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt,
                                         input logic allow_sub);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && allow_sub) ? 4'd1 : 4'd0;
      3'b001:  op = 4'd2;
      3'b010:  op = 4'd3;
      3'b011:  op = 4'd4;
      3'b100:  op = 4'd5;
      3'b101:  op = alt ? 4'd7 : 4'd6;
      3'b110:  op = 4'd8;
      default: op = 4'd9;
    endcase
    return op;
  endfunction

  always_comb begin
    case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LW;
      7'b0100011: dec_cls = C_SW;
      7'b1100011: dec_cls = C_BEQ;
      7'b1101111: dec_cls = C_JAL;
      7'b0110111: dec_cls = C_LUI;
      default:    dec_cls = C_BAD;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    illegal_d  = illegal_q;
    done       = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 1'b0;
    alu_op     = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        cls_d = dec_cls;
        case (dec_cls)
          C_BAD: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
          C_JAL, C_LUI: state_d = S_WB;
          default:      state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_R: begin
            alu_op  = alu_sel(funct3, funct7[5], 1'b1);
            state_d = S_WB;
          end
          C_I: begin
            alu_src_b = 1'b1;
            alu_op    = alu_sel(funct3, funct7[5], 1'b0);
            state_d   = S_WB;
          end
          C_LW, C_SW: begin
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          C_BEQ: begin
            alu_op   = 4'd1;
            pc_write = zero;
            pc_src   = zero;
            done     = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_MEM: begin
        if (cls_q == C_SW) begin
          mem_write = 1'b1;
          done      = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == C_LW);
        if (cls_q == C_JAL) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end
        done = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    if (done) state_d = run ? S_FETCH : S_IDLE;
    inst_count_d = inst_count_q + {31'd0, done};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cls_q        <= C_R;
      illegal_q    <= 1'b0;
      inst_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      illegal_q    <= illegal_d;
      inst_count_q <= inst_count_d;
    end
  end

  assign illegal     = illegal_q;
  assign watch_state = state_q;
  assign inst_count  = inst_count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state/enable/alu_op checks
// for each instruction class, reset behaviour and illegal-opcode halt.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [6:0]  funct7 = 7'd0;
  logic        zero = 1'b0;
  logic        pc_write, ir_write, reg_write, mem_write;
  logic        alu_src_a, alu_src_b, mem_to_reg, pc_src;
  logic [3:0]  alu_op;
  logic        illegal;
  logic [2:0]  watch_state;
  logic [31:0] inst_count;

  logic [7:0]  ctl;
  logic [14:0] obs;
  int total = 0;
  int bad   = 0;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .zero(zero), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_write(mem_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .mem_to_reg(mem_to_reg), .pc_src(pc_src),
    .alu_op(alu_op), .illegal(illegal), .watch_state(watch_state),
    .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  // {state, pc_write, ir_write, reg_write, mem_write, src_a, src_b, mem_to_reg, pc_src, alu_op}
  assign ctl = {pc_write, ir_write, reg_write, mem_write,
                alu_src_a, alu_src_b, mem_to_reg, pc_src};
  assign obs = {watch_state, ctl, alu_op};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b0;
    run = 1'b0;
    zero = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    total++;
    if (obs !== 15'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=%h", obs, 15'd0);
    end
    total++;
    if ({illegal, inst_count} !== 33'd0) begin
      bad++; $display("FAIL reset_illegal_count got=%h exp=0", {illegal, inst_count});
    end
    $display("test_reset: state=%0d inst_count=%0d", watch_state, inst_count);
  endtask

  task automatic test_r_add;
    logic [14:0] exp [5];
    exp = '{{3'd1, 8'hC0, 4'd0}, {3'd2, 8'h00, 4'd0}, {3'd3, 8'h00, 4'd0},
            {3'd5, 8'h20, 4'd0}, {3'd1, 8'hC0, 4'd0}};
    apply_reset();
    opcode = OP_R; funct3 = 3'b000; funct7 = 7'b0000000; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (obs !== exp[i]) begin
        bad++; $display("FAIL r_add_cycle%0d got=%h exp=%h", i, obs, exp[i]);
      end
    end
    total++;
    if (inst_count !== 32'd1) begin
      bad++; $display("FAIL r_add_count got=%0d exp=1", inst_count);
    end
    $display("test_r_add: inst_count=%0d", inst_count);
  endtask

  task automatic test_lw;
    logic [14:0] exp [5];
    exp = '{{3'd1, 8'hC0, 4'd0}, {3'd2, 8'h00, 4'd0}, {3'd3, 8'h04, 4'd0},
            {3'd4, 8'h00, 4'd0}, {3'd5, 8'h22, 4'd0}};
    apply_reset();
    opcode = OP_LW; funct3 = 3'b010; funct7 = 7'd0; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (obs !== exp[i]) begin
        bad++; $display("FAIL lw_cycle%0d got=%h exp=%h", i, obs, exp[i]);
      end
      if (i == 2) opcode = OP_BAD;
      if (i == 4) run = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({watch_state, inst_count} !== {3'd0, 32'd1}) begin
        bad++; $display("FAIL lw_idle_hold%0d got=%0d/%0d exp=0/1", i, watch_state, inst_count);
      end
    end
    $display("test_lw: state=%0d inst_count=%0d", watch_state, inst_count);
  endtask

  task automatic test_beq;
    logic [14:0] exp [6];
    exp = '{{3'd1, 8'hC0, 4'd0}, {3'd2, 8'h00, 4'd0}, {3'd3, 8'h81, 4'd1},
            {3'd1, 8'hC0, 4'd0}, {3'd2, 8'h00, 4'd0}, {3'd3, 8'h00, 4'd1}};
    apply_reset();
    opcode = OP_BEQ; funct3 = 3'b000; funct7 = 7'd0; zero = 1'b1; run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (obs !== exp[i]) begin
        bad++; $display("FAIL beq_cycle%0d got=%h exp=%h", i, obs, exp[i]);
      end
      if (i == 2) zero = 1'b0;
    end
    tick();
    total++;
    if ({watch_state, inst_count} !== {3'd1, 32'd2}) begin
      bad++; $display("FAIL beq_count got=%0d/%0d exp=1/2", watch_state, inst_count);
    end
    $display("test_beq: inst_count=%0d", inst_count);
  endtask

  task automatic test_alu_decode;
    logic [6:0]  ops [6];
    logic [2:0]  f3s [6];
    logic [6:0]  f7s [6];
    logic [11:0] exp [6];
    ops = '{OP_I, OP_R, OP_I, OP_R, OP_I, OP_R};
    f3s = '{3'b101, 3'b000, 3'b000, 3'b101, 3'b111, 3'b010};
    f7s = '{7'b0100000, 7'b0100000, 7'b0100000, 7'b0000000, 7'b0000000, 7'b0100000};
    exp = '{{8'h04, 4'd7}, {8'h00, 4'd1}, {8'h04, 4'd0},
            {8'h00, 4'd6}, {8'h04, 4'd9}, {8'h00, 4'd3}};
    for (int i = 0; i < 6; i++) begin
      apply_reset();
      opcode = ops[i]; funct3 = f3s[i]; funct7 = f7s[i]; run = 1'b1;
      repeat (3) tick();
      total++;
      if (obs !== {3'd3, exp[i]}) begin
        bad++; $display("FAIL alu_case%0d got=%h exp=%h", i, obs, {3'd3, exp[i]});
      end
      $display("test_alu_decode: case %0d alu_op=%0d", i, alu_op);
    end
  endtask

  task automatic test_back_to_back;
    logic [14:0] exp [6];
    exp = '{{3'd1, 8'hC0, 4'd0}, {3'd2, 8'h00, 4'd0}, {3'd5, 8'hA1, 4'd0},
            {3'd1, 8'hC0, 4'd0}, {3'd2, 8'h00, 4'd0}, {3'd5, 8'h20, 4'd0}};
    apply_reset();
    opcode = OP_JAL; funct3 = 3'd0; funct7 = 7'd0; run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (obs !== exp[i]) begin
        bad++; $display("FAIL jal_lui_cycle%0d got=%h exp=%h", i, obs, exp[i]);
      end
      if (i == 2) opcode = OP_LUI;
    end
    tick();
    total++;
    if ({watch_state, inst_count} !== {3'd1, 32'd2}) begin
      bad++; $display("FAIL jal_lui_count got=%0d/%0d exp=1/2", watch_state, inst_count);
    end
    $display("test_back_to_back: inst_count=%0d", inst_count);
  endtask

  task automatic test_sw_reset;
    logic [14:0] exp [4];
    exp = '{{3'd1, 8'hC0, 4'd0}, {3'd2, 8'h00, 4'd0}, {3'd3, 8'h04, 4'd0},
            {3'd4, 8'h10, 4'd0}};
    apply_reset();
    opcode = OP_SW; funct3 = 3'b010; funct7 = 7'd0; run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (obs !== exp[i % 4]) begin
        bad++; $display("FAIL sw_cycle%0d got=%h exp=%h", i, obs, exp[i % 4]);
      end
    end
    total++;
    if (inst_count !== 32'd1) begin
      bad++; $display("FAIL sw_count_before got=%0d exp=1", inst_count);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({obs, illegal, inst_count} !== 48'd0) begin
      bad++; $display("FAIL sw_async_reset got=%h exp=0", {obs, illegal, inst_count});
    end
    tick();
    total++;
    if (watch_state !== 3'd0) begin
      bad++; $display("FAIL reset_held_run got=%0d exp=0", watch_state);
    end
    rst = 1'b1;
    tick();
    total++;
    if (watch_state !== 3'd1) begin
      bad++; $display("FAIL reset_release_fetch got=%0d exp=1", watch_state);
    end
    $display("test_sw_reset: state=%0d inst_count=%0d", watch_state, inst_count);
  endtask

  task automatic test_illegal;
    apply_reset();
    opcode = OP_BAD; run = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({watch_state, illegal, ctl} !== {3'd6, 1'b1, 8'h00}) begin
        bad++; $display("FAIL halt_hold%0d got=%0d/%0d exp=6/1", i, watch_state, illegal);
      end
    end
    total++;
    if (inst_count !== 32'd0) begin
      bad++; $display("FAIL halt_count got=%0d exp=0", inst_count);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({watch_state, illegal} !== {3'd0, 1'b0}) begin
      bad++; $display("FAIL halt_reset got=%0d/%0d exp=0/0", watch_state, illegal);
    end
    rst = 1'b1;
    $display("test_illegal: state=%0d illegal=%0d", watch_state, illegal);
  endtask

  initial begin
    test_reset();
    test_r_add();
    test_lw();
    test_beq();
    test_alu_decode();
    test_back_to_back();
    test_sw_reset();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port run, input, 1 bit: permits leaving IDLE to start an instruction.
REQ-004 SHALL have ports opcode, input, 7 bits; funct3, input, 3 bits; funct7, input, 7 bits: decoded fields of the current IR from the fetch/decode stage.
REQ-005 SHALL have port zero, input, 1 bit: ALU result-is-zero flag, sampled in EXEC of a branch.
REQ-006 SHALL have ports pc_write, ir_write, reg_write, mem_write, output, 1 bit each: datapath write enables.
REQ-007 SHALL have ports alu_src_a (0=rs1, 1=PC) and alu_src_b (0=rs2, 1=imm32), output, 1 bit each; mem_to_reg, output, 1 bit (0=ALU result, 1=memory data); pc_src, output, 1 bit (0=PC+4, 1=branch/jump target).
REQ-008 SHALL have port alu_op, output, 4 bits: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
REQ-009 SHALL have ports illegal, output, 1 bit (sticky unsupported-opcode flag); watch_state, output, 3 bits; inst_count, output, 32 bits (completed instructions).

Function
REQ-010 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
REQ-011 SHALL transition IDLE->FETCH when run=1, else remain in IDLE.
REQ-012 SHALL in FETCH assert ir_write=1 and pc_write=1 with pc_src=0 for exactly one cycle, then go to DECODE.
REQ-013 SHALL in DECODE classify opcode: 0110011 R, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 BEQ, 1101111 JAL, 0110111 LUI; any other value -> HALT with illegal set.
REQ-014 SHALL sequence R/I-ALU: DECODE->EXEC->WB (4 cycles total).
REQ-015 SHALL sequence LW: DECODE->EXEC->MEM->WB (5 cycles); SW: DECODE->EXEC->MEM (4 cycles).
REQ-016 SHALL sequence BEQ: DECODE->EXEC (3 cycles); JAL and LUI: DECODE->WB (3 cycles).
REQ-017 SHALL after the final state of an instruction go to FETCH if run=1, else to IDLE.
REQ-018 SHALL in EXEC set alu_op: R from funct3 with funct7[5] selecting SUB (funct3=000) or SRA (funct3=101); I-ALU from funct3, funct7[5] selecting SRA only for funct3=101, never SUB; LW/SW ADD with alu_src_b=1; BEQ SUB with alu_src_b=0.
REQ-019 SHALL in BEQ EXEC assert pc_write=1, pc_src=1 only when zero=1.
REQ-020 SHALL in MEM assert mem_write=1 only for SW.
REQ-021 SHALL in WB assert reg_write=1 for one cycle; mem_to_reg=1 only for LW; for JAL also assert pc_write=1, pc_src=1.
REQ-022 SHALL drive every unlisted output to 0 in every state (Moore outputs from state plus held class).
REQ-023 SHALL latch instruction class in DECODE and hold it through the instruction; opcode changes after DECODE have no effect.
REQ-024 SHALL increment inst_count by 1 on the final cycle of each legal instruction, wrapping 0xFFFFFFFF->0.
REQ-025 SHALL remain in HALT with illegal=1 until reset; run ignored.
REQ-026 SHALL expose the current state encoding on watch_state.

Reset
REQ-027 SHALL on rst=0, at any time including mid-instruction, immediately force state=IDLE, illegal=0, inst_count=0, all enables 0, alu_op=0.
REQ-028 SHALL leave IDLE no earlier than the first rising edge after rst returns high with run=1.

Verification
REQ-029 R-type ADD (opcode 0110011, f3=000, f7=0000000), run=1 -> states 1,2,3,5,1; alu_op=0 in EXEC; reg_write=1 only in WB; inst_count=1.
REQ-030 LW (0000011) -> states 1,2,3,4,5; mem_to_reg=1 and reg_write=1 in WB; mem_write=0 throughout.
REQ-031 BEQ with zero=1 then zero=0 -> pc_write=1,pc_src=1 in EXEC first time only; alu_op=1 both times.
REQ-032 I-type f3=101,f7=0100000 -> alu_op=7; R-type f3=000,f7=0100000 -> alu_op=1; I-type f3=000,f7=0100000 -> alu_op=0.
REQ-033 opcode 1111111 in DECODE -> HALT (6), illegal=1, held with run=1 for 10 cycles; rst=0 -> IDLE, illegal=0.
REQ-034 rst=0 asserted during MEM of SW -> same-cycle IDLE, mem_write=0, inst_count=0; run=0 after an instruction -> IDLE held.
